// File: rtl/jojo_hit_manager.sv
// -----------------------------------------------------------------------------
// jojo_hit_manager
//
// Player-side hit handling for JOJO. Every clock the enemy sprite boxes are
// tested against JOJO's box. The result is registered into an overlap vector.
// A small FSM consumes that vector to apply damage, run the post-hit
// invincibility/blink window, track hit points and flag game over.
//
// Optional feature (compile-time macro):
//   JOJO_HP_REGEN_EN - when defined, JOJO regains one hit point per
//                      REGEN_CYCLES clocks spent in ALIVE below HP_MAX.
//                      When undefined there is no regen logic at all.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   jojo_x/y     in   JOJO top-left corner (10 bit each)
//   enemy_x/y    in   packed enemy top-left corners, enemy i at [10i+9:10i]
//   enemy_on     in   per-enemy active flag; an inactive enemy never hits
//   restart      in   single-cycle request to start a new life
//   hp           out  current hit points (0..HP_MAX)
//   hit_pulse    out  one-cycle strobe when damage is applied
//   hit_index    out  enemy that caused the most recent hit
//   invuln       out  high while in HURT
//   jojo_visible out  draw enable for the pixel mux (blinks while hurt)
//   game_over    out  high while in DEAD
//   state_dbg    out  raw FSM state (ALIVE=0, HURT=1, DEAD=2) for observation
//
// Timing: inputs sampled at edge k land in the overlap register. At edge k+1
// the FSM acts on that register. A hit therefore shows on hit_pulse two edges
// after the stimulus was presented.
// -----------------------------------------------------------------------------
module jojo_hit_manager #(
  parameter int N_ENEMY       = 4,
  parameter int T_W           = 32,
  parameter int HP_MAX        = 5,
  parameter int INVULN_CYCLES = 50000000,
  parameter int BLINK_CYCLES  = 2500000,
  parameter int REGEN_CYCLES  = 200000000,
  localparam int IDX_W        = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [9:0]             jojo_x,
  input  logic [9:0]             jojo_y,
  input  logic [10*N_ENEMY-1:0]  enemy_x,
  input  logic [10*N_ENEMY-1:0]  enemy_y,
  input  logic [N_ENEMY-1:0]     enemy_on,
  input  logic                   restart,
  output logic [3:0]             hp,
  output logic                   hit_pulse,
  output logic [IDX_W-1:0]       hit_index,
  output logic                   invuln,
  output logic                   jojo_visible,
  output logic                   game_over,
  output logic [1:0]             state_dbg
);

  // Counter widths sized to hold (CYCLES-1).
  localparam int INV_W   = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [3:0]         HP_INIT   = 4'(HP_MAX);
  localparam logic [10:0]        TW11      = 11'(T_W);
  localparam logic [INV_W-1:0]   INV_LAST  = INV_W'(INVULN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  // Elaboration-time guard on the parameter ranges the logic relies on.
  if (N_ENEMY < 1 || HP_MAX < 1 || HP_MAX > 15 || INVULN_CYCLES < 1 ||
      BLINK_CYCLES < 1 || REGEN_CYCLES < 1) begin : g_bad_params
    $error("jojo_hit_manager: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_HURT  = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Overlap stage
  // ---------------------------------------------------------------------------
  logic [N_ENEMY-1:0] ov_q;
  logic [N_ENEMY-1:0] ov_d;

  // All coordinates are widened to 11 bits before adding T_W. Boxes near the
  // right/bottom edge therefore never wrap into a false contact. Strict '<'
  // means touching edges do not count as contact.
  always_comb begin
    logic [10:0] jx;
    logic [10:0] jy;
    logic [10:0] ex;
    logic [10:0] ey;
    jx   = {1'b0, jojo_x};
    jy   = {1'b0, jojo_y};
    ex   = '0;
    ey   = '0;
    ov_d = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      ex = {1'b0, enemy_x[10*i +: 10]};
      ey = {1'b0, enemy_y[10*i +: 10]};
      ov_d[i] = enemy_on[i] &&
                (jx < ex + TW11) && (ex < jx + TW11) &&
                (jy < ey + TW11) && (ey < jy + TW11);
    end
  end

  // Lowest-index overlapping enemy wins; only one hit is taken per cycle.
  logic             any_ov;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    any_ov  = |ov_q;
    win_idx = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (ov_q[i]) win_idx = IDX_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_q,   state_d;
  logic [3:0]         hp_q,      hp_d;
  logic               pulse_q,   pulse_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic               vis_q,     vis_d;
  logic [INV_W-1:0]   inv_q,     inv_d;
  logic [BLINK_W-1:0] blink_q,   blink_d;
`ifdef JOJO_HP_REGEN_EN
  localparam int REGEN_W = (REGEN_CYCLES > 1) ? $clog2(REGEN_CYCLES) : 1;
  localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(REGEN_CYCLES - 1);
  logic [REGEN_W-1:0] regen_q,   regen_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ALIVE;
      hp_q    <= HP_INIT;
      pulse_q <= 1'b0;
      idx_q   <= '0;
      vis_q   <= 1'b1;
      inv_q   <= '0;
      blink_q <= '0;
      ov_q    <= '0;
`ifdef JOJO_HP_REGEN_EN
      regen_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      pulse_q <= pulse_d;
      idx_q   <= idx_d;
      vis_q   <= vis_d;
      inv_q   <= inv_d;
      blink_q <= blink_d;
      ov_q    <= ov_d;
`ifdef JOJO_HP_REGEN_EN
      regen_q <= regen_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    pulse_d = 1'b0;
    idx_d   = idx_q;
    vis_d   = vis_q;
    inv_d   = inv_q;
    blink_d = blink_q;
`ifdef JOJO_HP_REGEN_EN
    regen_d = regen_q;
`endif

    if (restart) begin
      // restart takes priority over any hit seen this cycle; hit_index is kept.
      state_d = ST_ALIVE;
      hp_d    = HP_INIT;
      vis_d   = 1'b1;
      inv_d   = '0;
      blink_d = '0;
`ifdef JOJO_HP_REGEN_EN
      regen_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (any_ov) begin
            pulse_d = 1'b1;
            idx_d   = win_idx;
`ifdef JOJO_HP_REGEN_EN
            regen_d = '0;
`endif
            if (hp_q <= 4'd1) begin
              state_d = ST_DEAD;
              hp_d    = '0;
            end else begin
              state_d = ST_HURT;
              hp_d    = hp_q - 4'd1;
              inv_d   = INV_LAST;
              blink_d = '0;
              vis_d   = 1'b0;
            end
          end
`ifdef JOJO_HP_REGEN_EN
          else if (hp_q < HP_INIT) begin
            if (regen_q == REGEN_LAST) begin
              hp_d    = hp_q + 4'd1;
              regen_d = '0;
            end else begin
              regen_d = regen_q + 1'b1;
            end
          end else begin
            regen_d = '0;
          end
`endif
        end

        ST_HURT: begin
`ifdef JOJO_HP_REGEN_EN
          regen_d = '0;
`endif
          if (inv_q == '0) begin
            // Window over: back to ALIVE, where overlap is evaluated again
            // on the very next edge.
            state_d = ST_ALIVE;
            vis_d   = 1'b1;
            blink_d = '0;
          end else begin
            inv_d = inv_q - 1'b1;
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              vis_d   = ~vis_q;
            end else begin
              blink_d = blink_q + 1'b1;
            end
          end
        end

        ST_DEAD: begin
          hp_d  = '0;
          vis_d = 1'b1;
`ifdef JOJO_HP_REGEN_EN
          regen_d = '0;
`endif
        end

        default: begin
          state_d = ST_ALIVE;
          vis_d   = 1'b1;
        end
      endcase
    end
  end

  assign hp           = hp_q;
  assign hit_pulse    = pulse_q;
  assign hit_index    = idx_q;
  assign jojo_visible = vis_q;
  assign invuln       = (state_q == ST_HURT);
  assign game_over    = (state_q == ST_DEAD);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_jojo_hit_manager.sv
module tb_jojo_hit_manager;

  localparam int N_ENEMY       = 4;
  localparam int T_W           = 32;
  localparam int HP_MAX        = 3;
  localparam int INVULN_CYCLES = 20;
  localparam int BLINK_CYCLES  = 4;
  localparam int REGEN_CYCLES  = 8;
  localparam int IDX_W         = 2;
  localparam int EXP_W         = 10;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]            jojo_x = '0;
  logic [9:0]            jojo_y = '0;
  logic [10*N_ENEMY-1:0] enemy_x = '0;
  logic [10*N_ENEMY-1:0] enemy_y = '0;
  logic [N_ENEMY-1:0]    enemy_on = '0;
  logic                  restart = 1'b0;
  logic [3:0]            hp;
  logic                  hit_pulse;
  logic [IDX_W-1:0]      hit_index;
  logic                  invuln;
  logic                  jojo_visible;
  logic                  game_over;
  logic [1:0]            state_dbg;

  jojo_hit_manager #(
    .N_ENEMY(N_ENEMY), .T_W(T_W), .HP_MAX(HP_MAX),
    .INVULN_CYCLES(INVULN_CYCLES), .BLINK_CYCLES(BLINK_CYCLES),
    .REGEN_CYCLES(REGEN_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .jojo_x(jojo_x), .jojo_y(jojo_y),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_on(enemy_on),
    .restart(restart),
    .hp(hp), .hit_pulse(hit_pulse), .hit_index(hit_index),
    .invuln(invuln), .jojo_visible(jojo_visible), .game_over(game_over),
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Inputs as the DUT sees them at the next rising edge.
  int                 s_jx, s_jy;
  int                 s_ex[N_ENEMY];
  int                 s_ey[N_ENEMY];
  logic [N_ENEMY-1:0] s_on;
  logic               s_restart;

  always @(negedge clk) begin
    s_jx = jojo_x;
    s_jy = jojo_y;
    for (int i = 0; i < N_ENEMY; i++) begin
      s_ex[i] = enemy_x[10*i +: 10];
      s_ey[i] = enemy_y[10*i +: 10];
    end
    s_on      = enemy_on;
    s_restart = restart;
  end

  int               m_hp, m_hurt_left, m_age, m_idx, m_regen;
  bit               m_dead, m_pulse;
  bit [N_ENEMY-1:0] m_ov;
  logic [EXP_W-1:0] exp_q[$];

  function automatic bit boxes_touch(int jx, int jy, int ex, int ey);
    return (jx < ex + T_W) && (ex < jx + T_W) && (jy < ey + T_W) && (ey < jy + T_W);
  endfunction

  task automatic model_reset();
    m_hp = HP_MAX; m_hurt_left = 0; m_age = 0; m_idx = 0; m_regen = 0;
    m_dead = 0; m_pulse = 0; m_ov = '0;
  endtask

  // One clock of game rules, acting on the overlap seen one edge earlier.
  task automatic model_step();
    bit [N_ENEMY-1:0] nov;
    for (int i = 0; i < N_ENEMY; i++)
      nov[i] = s_on[i] && boxes_touch(s_jx, s_jy, s_ex[i], s_ey[i]);
    m_pulse = 0;
    if (s_restart) begin
      m_hp = HP_MAX; m_hurt_left = 0; m_dead = 0; m_regen = 0;
    end else if (m_dead) begin
      m_hp = 0;
    end else if (m_hurt_left > 0) begin
      m_hurt_left--;
      m_age++;
    end else if (m_ov != 0) begin
      int w;
      w = 0;
      while (!m_ov[w]) w++;
      m_hp--; m_pulse = 1; m_idx = w; m_regen = 0;
      if (m_hp == 0) m_dead = 1;
      else begin m_hurt_left = INVULN_CYCLES; m_age = 0; end
    end else begin
`ifdef JOJO_HP_REGEN_EN
      if (m_hp < HP_MAX) begin
        m_regen++;
        if (m_regen == REGEN_CYCLES) begin m_hp++; m_regen = 0; end
      end else m_regen = 0;
`endif
    end
    m_ov = nov;
  endtask

  function automatic logic [EXP_W-1:0] model_outputs();
    bit vis;
    vis = (m_hurt_left > 0) ? (((m_age / BLINK_CYCLES) % 2) == 1) : 1'b1;
    return {4'(m_hp), m_pulse, IDX_W'(m_idx), (m_hurt_left > 0), vis, m_dead};
  endfunction

  // Compare process: every cycle, after outputs settle.
  always begin
    logic [EXP_W-1:0] e;
    @(posedge clk);
    #3;
    if (!reset_n) model_reset();
    else model_step();
    exp_q.push_back(model_outputs());
    e = exp_q.pop_front();
    chk("cyc_hp",      hp,           e[9:6]);
    chk("cyc_pulse",   hit_pulse,    e[5]);
    chk("cyc_index",   hit_index,    e[4:3]);
    chk("cyc_invuln",  invuln,       e[2]);
    chk("cyc_visible", jojo_visible, e[1]);
    chk("cyc_gameover", game_over,   e[0]);
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #4;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_enemies();
    enemy_on = '0; enemy_x = '0; enemy_y = '0;
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    enemy_x[10*i +: 10] = 10'(x);
    enemy_y[10*i +: 10] = 10'(y);
    enemy_on[i] = 1'b1;
  endtask

  task automatic set_jojo(input int x, input int y);
    jojo_x = 10'(x); jojo_y = 10'(y);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // Reset with nothing on screen.
    ticks(3);
    chk("rst_hp", hp, 3);
    chk("rst_gameover", game_over, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_visible", jojo_visible, 1);
    chk("rst_pulse", hit_pulse, 0);
    chk("rst_index", hit_index, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_pulse", hit_pulse, 0);
    end

    // First hit and the blink window.
    set_jojo(120, 120);
    set_enemy(0, 100, 100);
    tick();
    chk("hit1_early", hit_pulse, 0);
    tick();
    chk("hit1_pulse", hit_pulse, 1);
    chk("hit1_index", hit_index, 0);
    chk("hit1_hp", hp, 2);
    chk("hit1_invuln", invuln, 1);
    chk("blink_c1", jojo_visible, 0);
    for (int c = 2; c <= INVULN_CYCLES; c++) begin
      tick();
      chk("hurt_invuln", invuln, 1);
      chk("hurt_pulse", hit_pulse, 0);
      chk("blink", jojo_visible, ((c - 1) / BLINK_CYCLES) % 2);
    end
    tick();
    chk("exit_invuln", invuln, 0);
    chk("exit_visible", jojo_visible, 1);
    chk("exit_pulse", hit_pulse, 0);
    tick();
    chk("hit2_pulse", hit_pulse, 1);
    chk("hit2_hp", hp, 1);
    clear_enemies();
    ticks(25);
    chk("hit2_recover", invuln, 0);

    // Boundaries.
    do_restart();
    chk("restart_hp", hp, 3);
    set_jojo(132, 100);
    set_enemy(0, 100, 100);
    ticks(3);
    chk("touch_x_hp", hp, 3);
    set_jojo(131, 100);
    tick();
    tick();
    chk("x131_pulse", hit_pulse, 1);
    chk("x131_hp", hp, 2);
    clear_enemies();
    ticks(22);
    set_jojo(100, 68);
    set_enemy(0, 100, 100);
    ticks(3);
    chk("touch_y_hp", hp, 2);
    set_jojo(5, 100);
    set_enemy(0, 620, 100);
    ticks(3);
    chk("far_x_hp", hp, 2);
    set_jojo(100, 100);
    set_enemy(0, 100, 100);
    enemy_on = '0;
    ticks(3);
    chk("off_hp", hp, 2);
    clear_enemies();

    // Two overlapping enemies, lowest index wins.
    do_restart();
    set_jojo(200, 200);
    set_enemy(1, 210, 190);
    set_enemy(3, 200, 200);
    tick();
    tick();
    chk("multi_pulse", hit_pulse, 1);
    chk("multi_index", hit_index, 1);
    chk("multi_hp", hp, 2);
    clear_enemies();
    tick();
    chk("multi_single", hit_pulse, 0);
    ticks(22);

    // Run down to DEAD, then restart.
    do_restart();
    set_jojo(300, 300);
    for (int h = 2; h >= 0; h--) begin
      set_enemy(0, 300, 300);
      tick();
      tick();
      chk("drain_pulse", hit_pulse, 1);
      chk("drain_hp", hp, h);
      clear_enemies();
      ticks(22);
    end
    chk("dead_gameover", game_over, 1);
    chk("dead_visible", jojo_visible, 1);
    chk("dead_invuln", invuln, 0);
    set_enemy(0, 300, 300);
    ticks(5);
    chk("dead_hp", hp, 0);
    chk("dead_still", game_over, 1);
    clear_enemies();
    tick();
    do_restart();
    chk("revive_hp", hp, 3);
    chk("revive_gameover", game_over, 0);

    // restart coincident with a pending hit.
    set_enemy(0, 300, 300);
    tick();
    restart = 1'b1;
    clear_enemies();
    tick();
    restart = 1'b0;
    chk("rs_hit_hp", hp, 3);
    chk("rs_hit_pulse", hit_pulse, 0);
    tick();
    chk("rs_hit_after", hit_pulse, 0);

    // Asynchronous reset in the middle of HURT.
    set_enemy(2, 300, 300);
    tick();
    tick();
    chk("ar_pulse", hit_pulse, 1);
    chk("ar_index", hit_index, 2);
    clear_enemies();
    ticks(9);
    chk("ar_hurt", invuln, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_hp", hp, 3);
    chk("ar_index0", hit_index, 0);
    chk("ar_invuln", invuln, 0);
    chk("ar_visible", jojo_visible, 1);
    chk("ar_gameover", game_over, 0);
    chk("ar_pulse0", hit_pulse, 0);
    ticks(2);
    reset_n = 1'b1;
    tick();
    chk("ar_after_hp", hp, 3);

`ifdef JOJO_HP_REGEN_EN
    set_enemy(0, 300, 300);
    tick();
    tick();
    chk("regen_hit_hp", hp, 2);
    clear_enemies();
    ticks(27);
    chk("regen_before", hp, 2);
    tick();
    chk("regen_after", hp, 3);
    ticks(20);
    chk("regen_hold", hp, 3);
`endif

    // Randomised play against the model.
    for (int n = 0; n < 3000; n++) begin
      int jx, jy, x, y;
      jx = $urandom_range(0, 991);
      jy = $urandom_range(0, 991);
      set_jojo(jx, jy);
      for (int i = 0; i < N_ENEMY; i++) begin
        x = jx + int'($urandom_range(0, 80)) - 40;
        y = jy + int'($urandom_range(0, 80)) - 40;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        enemy_x[10*i +: 10] = 10'(x);
        enemy_y[10*i +: 10] = 10'(y);
        enemy_on[i] = ($urandom_range(0, 3) == 0);
      end
      restart = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      tick();
    end
    restart = 1'b0;
    clear_enemies();
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
